// File: rtl/dice_round_ctrl.sv
// ---------------------------------------------------------------------------
// dice_round_ctrl
//
// Round/score controller for a two-player dice game. Each round is started
// by a start pulse, scored on the first legal dice_valid, and followed by a
// result-hold period. After ROUNDS rounds the winner-display period runs,
// then the block parks in DONE until start begins a new game.
//
// Parameters
//   ROUNDS        rounds per game (1..15)
//   HOLD_CYCLES   result-hold cycles after each round (>= 1)
//   FINAL_CYCLES  winner-display cycles (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        single-cycle pulse: begin a round / a new game
//   dice1/dice2  die values, legal 1..6
//   dice_valid   single-cycle pulse: dice1/dice2 valid this cycle
//   times        animation enable for the LED display stage
//   is_final     game over, display shows the winner
//   is_finish    winner display period has elapsed
//   score1/2     player points
//   round        completed-round count
// ---------------------------------------------------------------------------
module dice_round_ctrl #(
    parameter int ROUNDS       = 5,
    parameter int HOLD_CYCLES  = 1_000_000,
    parameter int FINAL_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] dice1,
    input  logic [2:0] dice2,
    input  logic       dice_valid,
    output logic       times,
    output logic       is_final,
    output logic       is_finish,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] round
);

    // One shared counter serves both the hold and the final periods; it is
    // wide enough for the larger of the two.
    localparam int CNT_MAX = (HOLD_CYCLES > FINAL_CYCLES) ? HOLD_CYCLES : FINAL_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] FINAL_LAST = CW'(FINAL_CYCLES - 1);
    localparam logic [3:0]    ROUNDS_L   = 4'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROLL  = 3'd1,
        HOLD  = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    score1_next, score2_next, round_next;
    logic          times_next, is_final_next, is_finish_next;
    logic          dice_legal;

    // A die value of 0 or 7 cannot come from a real die.
    assign dice_legal = (dice1 != 3'd0) && (dice1 != 3'd7) &&
                        (dice2 != 3'd0) && (dice2 != 3'd7);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        score1_next = score1;
        score2_next = score2;
        round_next  = round;

        case (state_reg)
            IDLE: begin
                // start wins over any dice_valid seen in the same cycle
                if (start) begin
                    state_next = ROLL;
                end
            end
            ROLL: begin
                if (dice_valid && dice_legal) begin
                    if (dice1 > dice2) begin
                        score1_next = score1 + 4'd1;
                    end else if (dice2 > dice1) begin
                        score2_next = score2 + 4'd1;
                    end
                    round_next = round + 4'd1;
                    cnt_next   = '0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next   = '0;
                    state_next = (round == ROUNDS_L) ? FINAL : IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FINAL: begin
                if (cnt_reg == FINAL_LAST) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    score1_next = 4'd0;
                    score2_next = 4'd0;
                    round_next  = 4'd0;
                    state_next  = ROLL;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Status flags are decoded from the next state so that the registered
        // copies line up with the state they describe.
        times_next     = (state_next == ROLL) || (state_next == FINAL);
        is_final_next  = (state_next == FINAL) || (state_next == DONE);
        is_finish_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            round     <= 4'd0;
            times     <= 1'b0;
            is_final  <= 1'b0;
            is_finish <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            score1    <= score1_next;
            score2    <= score2_next;
            round     <= round_next;
            times     <= times_next;
            is_final  <= is_final_next;
            is_finish <= is_finish_next;
        end
    end

endmodule
